// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and widths.
package serial_sub_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_ctrl_full_sub.sv
// One-bit subtractor slice: a full subtractor assembled from two half subtractors.
module half_sub (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bout
);

    assign d    = a ^ b;
    assign bout = ~a & b;

endmodule

module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    half_sub hs_ab (
        .a    (a),
        .b    (b),
        .d    (d1),
        .bout (b1)
    );

    // Second stage subtracts the incoming borrow from the partial difference.
    half_sub hs_bin (
        .a    (d1),
        .b    (bin),
        .d    (d),
        .bout (b2)
    );

    assign bout = b1 | b2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor controller, LSB-first, one bit per clock.
// Define SERIAL_SUB_SAT_EN to clamp underflowing results to zero.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             bout_bit;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    full_sub slice (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // The newest bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
    assign res_next = {d_bit, res_sr};
    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        brw  <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next[WIDTH-1:1];
                    brw    <= bout_bit;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
`ifdef SERIAL_SUB_SAT_EN
                        diff <= bout_bit ? '0 : res_next;
`else
                        diff <= res_next;
`endif
                        borrow_out <= bout_bit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed self-checking bench for serial_sub_ctrl (WIDTH 8 and WIDTH 4 instances).
module tb_serial_sub_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       borrow_out4;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] exp_diff;
        logic       exp_brw;
    } vec_t;

    vec_t vecs [6];

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start4),
        .a          (a4),
        .b          (b4),
        .busy       (busy4),
        .done       (done4),
        .diff       (diff4),
        .borrow_out (borrow_out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] satAdj(input logic [7:0] d, input logic br);
`ifdef SERIAL_SUB_SAT_EN
        return br ? 8'h00 : d;
`else
        return d;
`endif
    endfunction

    // Runs one operation, scrambling a/b right after acceptance; returns result and timing.
    task automatic applyStimulus(input logic [7:0] op_a, input logic [7:0] op_b,
                                 output logic [7:0] r_diff, output logic r_brw,
                                 output int lat, output int busy_n, output logic done_after);
        @(negedge clk);
        start = 1'b1;
        a = op_a;
        b = op_b;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~op_a;
        b = ~op_b;
        lat = 0;
        busy_n = 0;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout actual=%0d required=8", lat);
        end
        r_diff = diff;
        r_brw = borrow_out;
        @(posedge clk);
        #1;
        done_after = done;
    endtask

    initial begin
        logic [7:0] r_diff;
        logic       r_brw;
        int         lat;
        int         busy_n;
        logic       done_after;
        logic       saw_done;
        logic [7:0] hist_a [64];
        logic [7:0] hist_b [64];
        int         n_done;
        int         last_done;
        logic [8:0] full;

        checks = 0;
        errors = 0;
        start = 1'b0;
        a = '0;
        b = '0;
        start4 = 1'b0;
        a4 = '0;
        b4 = '0;

        vecs[0] = '{8'h35, 8'h12, 8'h23, 1'b0};
        vecs[1] = '{8'h12, 8'h35, 8'hDD, 1'b1};
        vecs[2] = '{8'hFF, 8'h01, 8'hFE, 1'b0};
        vecs[3] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[5] = '{8'hA5, 8'h5A, 8'h4B, 1'b0};

        rst_n = 1'b0;
        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_diff", diff, 0);
        checkOutput("rst_borrow", borrow_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].va, vecs[i].vb, r_diff, r_brw, lat, busy_n, done_after);
            checkOutput($sformatf("vec%0d_diff", i), r_diff, satAdj(vecs[i].exp_diff, vecs[i].exp_brw));
            checkOutput($sformatf("vec%0d_borrow", i), r_brw, vecs[i].exp_brw);
            checkOutput($sformatf("vec%0d_latency", i), lat, 8);
            checkOutput($sformatf("vec%0d_busy_cycles", i), busy_n, 8);
            checkOutput($sformatf("vec%0d_done_pulse", i), done_after, 0);
        end

        // Asynchronous reset in the 4th RUN cycle.
        @(negedge clk);
        start = 1'b1;
        a = 8'h55;
        b = 8'h22;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        checkOutput("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_busy", busy, 0);
        checkOutput("async_done", done, 0);
        checkOutput("async_diff", diff, 0);
        checkOutput("async_borrow", borrow_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        checkOutput("no_done_after_reset", saw_done, 0);
        checkOutput("idle_after_reset", busy, 0);
        applyStimulus(8'h80, 8'h01, r_diff, r_brw, lat, busy_n, done_after);
        checkOutput("post_reset_diff", r_diff, 8'h7F);
        checkOutput("post_reset_borrow", r_brw, 0);

        // start held high for 30 cycles with operands changing every cycle.
        n_done = 0;
        last_done = -1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            start = (i < 30);
            a = 8'(i * 37 + 5);
            b = 8'(i * 53 + 200);
            hist_a[i] = a;
            hist_b[i] = b;
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                if (i < 8) begin
                    checkOutput("stream_early_done", i, 8);
                end else begin
                    full = {1'b0, hist_a[i-8]} - {1'b0, hist_b[i-8]};
                    checkOutput($sformatf("stream_diff_e%0d", i), diff, satAdj(full[7:0], full[8]));
                    checkOutput($sformatf("stream_borrow_e%0d", i), borrow_out, full[8]);
                end
                if (last_done >= 0) checkOutput("stream_spacing", i - last_done, 10);
                last_done = i;
            end
        end
        checkOutput("stream_done_count", n_done, 3);

        // WIDTH 4 instance.
        @(negedge clk);
        start4 = 1'b1;
        a4 = 4'h3;
        b4 = 4'h5;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        a4 = 4'hF;
        b4 = 4'h0;
        lat = 0;
        while (!done4 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("w4_latency", lat, 4);
`ifdef SERIAL_SUB_SAT_EN
        checkOutput("w4_diff", diff4, 4'h0);
`else
        checkOutput("w4_diff", diff4, 4'hE);
`endif
        checkOutput("w4_borrow", borrow_out4, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial unsigned subtractor controller. It latches two WIDTH-bit operands on a start pulse, then sequences one full-subtractor bit-slice LSB-first, one bit per clock, while carrying the borrow between bits. It reports the WIDTH-bit difference and the final borrow with a one-cycle done pulse. The block is the sequencing wrapper around the team's half/full subtractor datapath, for designs that trade latency for area.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk, input, 1, single system clock; rising-edge active.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request a subtraction; sampled only in IDLE.
- a, input, WIDTH, minuend; latched on the accepted start.
- b, input, WIDTH, subtrahend; latched on the accepted start.
- busy, output, 1, high while in RUN.
- done, output, 1, one-cycle pulse when the result becomes valid.
- diff, output, WIDTH, a - b modulo 2^WIDTH; held until the next accepted start.
- borrow_out, output, 1, final borrow (1 = a < b); held with diff.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
- While rst_n = 0:
  - state = IDLE;
  - busy, done, borrow_out = 0;
  - diff = 0;
  - internal shift registers, borrow register and bit counter = 0.
- Reset asserted mid-RUN aborts the operation. No done pulse is issued, and partial results are discarded.
- States are IDLE, RUN and DONE. All state and output registers update on the rising edge of clk.
- IDLE:
  - If start = 1, latch a and b into shift registers, clear the borrow register and clear the counter. Next state is RUN.
  - Otherwise stay in IDLE.
- RUN: on each edge, feed bit0 of the a and b shift registers and the borrow register into the full subtractor.
  - Bit equations: d = a0 ^ b0 ^ bin; bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
  - Shift d into the result register from the MSB end, shift both operand registers right, store bout, and increment the counter.
  - After the WIDTH-th RUN edge, go to DONE.
  - On that same edge, load diff from the completed result register and load borrow_out from the final bout.
- DONE: done = 1 for exactly this one cycle. Next state is IDLE unconditionally.
- Latency: start is sampled at edge E0. done is high in the cycle after edge E(WIDTH). The next start can be accepted at edge E(WIDTH+2).
- start is ignored in RUN and DONE. It is not queued. Holding start high continuously gives back-to-back operations with one IDLE cycle between them.
- Changes on a and b after the accepting edge have no effect on the result in flight.
- busy = (state == RUN). done = (state == DONE). Both are decoded from registered state, so they are glitch-free.
- diff and borrow_out change only on the edge that enters DONE, or on reset.
- The counter is $clog2(WIDTH+1) bits wide and never wraps within an operation.

Optional Feature:
- Macro: SERIAL_SUB_SAT_EN.
- Defined: unsigned saturation. If the final borrow = 1, diff is loaded with 0 instead of the wrapped value. borrow_out is still 1 and flags the underflow.
- Undefined: diff is the wrapped two's-complement result, a - b mod 2^WIDTH.
- Timing is identical in both builds.

Decomposition:
- Shared package serial_sub_pkg holds:
  - state encoding localparams: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  - the 2-bit state width constant.
- One natural sub-module: full_sub (a, b, bin -> d, bout). It is built from two half_sub instances plus an OR on their borrows, and is instantiated once as the bit-slice.
- The controller contains only the FSM, the shift registers, the counter and the output registers.

Test Plan (WIDTH = 8 unless noted):
- a = 8'h35, b = 8'h12, 1-cycle start → busy high for 8 cycles, then done for 1 cycle; diff = 8'h23, borrow_out = 0.
- a = 8'h12, b = 8'h35 → diff = 8'hDD, borrow_out = 1. With SERIAL_SUB_SAT_EN: diff = 8'h00, borrow_out = 1.
- Boundary operands:
  - a = 8'hFF, b = 8'h01 → diff = 8'hFE, borrow_out = 0.
  - a = 8'h00, b = 8'hFF → diff = 8'h01, borrow_out = 1.
  - a = b = 8'h00 → diff = 8'h00, borrow_out = 0.
- start held high for 30 cycles with a and b toggling every cycle:
  - each result matches the operands sampled at its accepting edge;
  - done pulses are exactly 10 cycles apart.
- rst_n pulsed low asynchronously (between edges) on the 4th RUN cycle:
  - busy, done, diff and borrow_out go to 0 immediately;
  - no done pulse follows;
  - a subsequent start with a = 8'h80, b = 8'h01 completes with diff = 8'h7F.
- WIDTH = 4, a = 4'h3, b = 4'h5 → done pulse 4 cycles after the accepting edge; diff = 4'hE, borrow_out = 1.
